edit_sequencer: RTL and testbench
=================================

EDIT_SEQUENCER -- requirements
Module: edit_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 40, the number of idle tick pulses (10 s at 4 Hz) before an edit state exits to RUN.
REQ-002 SHALL have parameter REPEAT_DELAY, default 4, the number of tick pulses a held up key waits before auto-repeat starts.
REQ-003 clock_50MHz  in  1  sole system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 tick_4Hz  in  1  4 Hz square wave, asynchronous to clock_50MHz.
REQ-006 key_mode_n  in  1  raw mode key, active-low, asynchronous.
REQ-007 key_shift_n  in  1  raw field-shift key, active-low, asynchronous.
REQ-008 key_up_n  in  1  raw increment key, active-low, asynchronous.
REQ-009 set  out  3  one-hot edit state: [0] clock, [1] date, [2] d-day; 000 in RUN.
REQ-010 up  out  15  one-cycle increment strobes: [2:0] clock fields, [8:3] date fields, [14:9] d-day fields.
REQ-011 select  out  15  one-hot marker of the field under edit, same bit map as up.
REQ-012 blink  out  1  display blink enable for the selected field.

Function
REQ-013 Each key input SHALL pass through a 2-flop synchronizer, then a press detector that outputs a one-cycle pulse on a high-to-low transition of the synchronized signal.
REQ-014 tick_4Hz SHALL pass through a 2-flop synchronizer, then a rising-edge detector that outputs a one-cycle tick pulse.
REQ-015 The FSM SHALL have four states: RUN, SET_CLOCK, SET_DATE, SET_DDAY.
REQ-016 Each mode press SHALL advance the state cyclically: RUN -> SET_CLOCK -> SET_DATE -> SET_DDAY -> RUN.
REQ-017 set SHALL be 000 in RUN, 001 in SET_CLOCK, 010 in SET_DATE and 100 in SET_DDAY.
REQ-018 The field cursor SHALL be 3 bits and SHALL clear to 0 on every state entry.
REQ-019 Each shift press SHALL increment the cursor; it wraps 2->0 in SET_CLOCK and 5->0 in SET_DATE and SET_DDAY.
REQ-020 Shift presses SHALL be ignored in RUN.
REQ-021 An up press in an edit state SHALL drive up[base+cursor] high for exactly one cycle; base is 0, 3 or 9 for SET_CLOCK, SET_DATE or SET_DDAY.
REQ-022 Up presses SHALL be ignored in RUN; up SHALL be all-zero except during the strobe cycle.
REQ-023 Latency: if key_up_n is first sampled low at edge k, up SHALL rise after edge k+2 and fall after edge k+3.
REQ-024 The same latency SHALL apply to set changes after a mode press and to cursor changes after a shift press.
REQ-025 Auto-repeat: while key_up remains held in an edit state, tick pulses SHALL be counted.
REQ-026 After REPEAT_DELAY tick pulses of holding, one further up strobe SHALL be issued on each subsequent tick pulse.
REQ-027 The hold count SHALL clear on release and on any state change.
REQ-028 select SHALL be registered and one-hot at bit base+cursor in edit states, and all-zero in RUN.
REQ-029 blink SHALL be 0 in RUN, SHALL load 1 on each state entry, and SHALL toggle on each tick pulse while in an edit state.
REQ-030 An idle counter SHALL count tick pulses in edit states and clear on any press or state change.
REQ-031 When the idle counter reaches TIMEOUT_TICKS, the FSM SHALL return to RUN on the next cycle.
REQ-032 Simultaneous presses in one cycle SHALL resolve with priority mode > shift > up; lower-priority presses in that cycle SHALL be discarded.
REQ-033 An up press coinciding with a timeout SHALL be discarded; the timeout wins.
REQ-034 Auto-repeat strobes SHALL count as up presses for REQ-030 and SHALL therefore keep the idle counter cleared.

Reset
REQ-035 While reset is 0 at a clock edge: state RUN, cursor 0, all counters 0, set=000, up=0, select=0, blink=0.
REQ-036 Also while reset is 0: key synchronizer flops load 1 and the tick synchronizer flops load 0, so release produces no false press or tick.
REQ-037 Reset asserted mid-edit SHALL abort the edit at that edge; any up strobe in flight SHALL be suppressed.

Verification
REQ-038 Reset, then 1 mode press -> set=001, select=15'h0001, blink=1; a 2nd press -> set=010, select=15'h0008.
REQ-039 SET_DATE, 6 shift presses -> select visits bits 3,4,5,6,7,8 then returns to bit 3; an up press at cursor 2 -> up=15'h0020 for exactly 1 cycle.
REQ-040 SET_CLOCK, key_up held for 8 ticks -> 1 press strobe plus 4 repeat strobes on up[0]; release -> no further strobes.
REQ-041 SET_DDAY with no presses for 40 ticks -> set=000, select=0, blink=0 on the cycle after the 40th tick.
REQ-042 Mode and up pressed in the same cycle from SET_CLOCK -> set=010 and no up strobe; reset asserted during an up strobe's latency window -> up stays 0.

Source files
------------

// File: rtl/edit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : edit_sequencer
// Brief    : Key/tick front end and edit-mode FSM for clock/date/d-day setting.
// Revision : 1.0
// ============================================================================
module edit_sequencer #(
    parameter int TIMEOUT_TICKS = 40,
    parameter int REPEAT_DELAY  = 4
) (
    input  logic        clock_50MHz,
    input  logic        reset,
    input  logic        tick_4Hz,
    input  logic        key_mode_n,
    input  logic        key_shift_n,
    input  logic        key_up_n,
    output logic [2:0]  set,
    output logic [14:0] up,
    output logic [14:0] select,
    output logic        blink
);
    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_CLOCK = 2'd1;
    localparam logic [1:0] c_ST_DATE  = 2'd2;
    localparam logic [1:0] c_ST_DDAY  = 2'd3;

    localparam int IW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
    localparam int HW = (REPEAT_DELAY < 2) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam logic [IW-1:0] c_IDLE_MAX = IW'(TIMEOUT_TICKS);
    localparam logic [HW-1:0] c_HOLD_MAX = HW'(REPEAT_DELAY);

    // Key vectors are {up, shift, mode}; synchronizers idle at the released level.
    logic [2:0]    r_key_s1, r_key_s2, r_key_d;
    logic          r_tick_s1, r_tick_s2, r_tick_d;
    logic [1:0]    r_state;
    logic [2:0]    r_cursor;
    logic [IW-1:0] r_idle;
    logic [HW-1:0] r_hold;
    logic [14:0]   r_up, r_select;
    logic          r_blink;

    logic [2:0]    w_press;
    logic          w_tick, w_edit, w_timeout, w_held, w_repeat;
    logic          w_mode, w_shift, w_upev, w_strobe, w_change;
    logic [1:0]    w_state_nxt;
    logic [2:0]    w_cursor_nxt, w_cur_max;
    logic [14:0]   w_up_nxt, w_sel_nxt;

    function automatic logic [3:0] f_base(input logic [1:0] st);
        case (st)
            c_ST_DATE: return 4'd3;
            c_ST_DDAY: return 4'd9;
            default:   return 4'd0;
        endcase
    endfunction

    assign w_press   = r_key_d & ~r_key_s2;
    assign w_tick    = r_tick_s2 & ~r_tick_d;
    assign w_edit    = (r_state != c_ST_RUN);
    assign w_timeout = w_edit && (r_idle == c_IDLE_MAX);
    assign w_held    = w_edit && !r_key_s2[2];
    assign w_repeat  = w_held && w_tick && (r_hold == c_HOLD_MAX);
    assign w_mode    = w_press[0];
    assign w_shift   = w_press[1] & ~w_press[0];
    assign w_upev    = (w_press[2] | w_repeat) & ~w_press[0] & ~w_press[1];
    assign w_cur_max = (r_state == c_ST_CLOCK) ? 3'd2 : 3'd5;

    always_comb begin
        w_state_nxt  = r_state;
        w_cursor_nxt = r_cursor;
        w_strobe     = 1'b0;
        if (w_timeout) begin
            w_state_nxt = c_ST_RUN;
        end else if (w_mode) begin
            w_state_nxt = r_state + 2'd1;
        end else if (w_edit && w_shift) begin
            w_cursor_nxt = (r_cursor == w_cur_max) ? 3'd0 : r_cursor + 3'd1;
        end else if (w_edit && w_upev) begin
            w_strobe = 1'b1;
        end
        w_change = (w_state_nxt != r_state);
        if (w_change) begin
            w_cursor_nxt = 3'd0;
        end
        w_up_nxt  = w_strobe ? (15'd1 << (f_base(r_state) + {1'b0, r_cursor})) : 15'd0;
        w_sel_nxt = (w_state_nxt == c_ST_RUN) ? 15'd0
                  : (15'd1 << (f_base(w_state_nxt) + {1'b0, w_cursor_nxt}));
    end

    always_ff @(posedge clock_50MHz) begin
        if (!reset) begin
            r_key_s1  <= 3'b111;
            r_key_s2  <= 3'b111;
            r_key_d   <= 3'b111;
            r_tick_s1 <= 1'b0;
            r_tick_s2 <= 1'b0;
            r_tick_d  <= 1'b0;
            r_state   <= c_ST_RUN;
            r_cursor  <= 3'd0;
            r_idle    <= '0;
            r_hold    <= '0;
            r_up      <= 15'd0;
            r_select  <= 15'd0;
            r_blink   <= 1'b0;
        end else begin
            r_key_s1  <= {key_up_n, key_shift_n, key_mode_n};
            r_key_s2  <= r_key_s1;
            r_key_d   <= r_key_s2;
            r_tick_s1 <= tick_4Hz;
            r_tick_s2 <= r_tick_s1;
            r_tick_d  <= r_tick_s2;
            r_state   <= w_state_nxt;
            r_cursor  <= w_cursor_nxt;
            r_up      <= w_up_nxt;
            r_select  <= w_sel_nxt;

            if (w_state_nxt == c_ST_RUN)
                r_blink <= 1'b0;
            else if (w_change)
                r_blink <= 1'b1;
            else if (w_tick)
                r_blink <= ~r_blink;

            // Any press, including discarded ones and repeat strobes, restarts the timeout.
            if (w_state_nxt == c_ST_RUN || w_change || (|w_press) || w_repeat)
                r_idle <= '0;
            else if (w_tick && r_idle != c_IDLE_MAX)
                r_idle <= r_idle + 1'b1;

            if (!w_held || w_change)
                r_hold <= '0;
            else if (w_tick && r_hold != c_HOLD_MAX)
                r_hold <= r_hold + 1'b1;
        end
    end

    always_comb begin
        case (r_state)
            c_ST_CLOCK: set = 3'b001;
            c_ST_DATE:  set = 3'b010;
            c_ST_DDAY:  set = 3'b100;
            default:    set = 3'b000;
        endcase
    end

    assign up     = r_up;
    assign select = r_select;
    assign blink  = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_edit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_edit_sequencer
// Brief    : Scenario tasks plus randomized operation stream against a model.
// Revision : 1.0
// ============================================================================
module tb_edit_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, tick, kmode, kshift, kup;
    logic [2:0]  set;
    logic [14:0] up, select;
    logic        blink;

    int          errors = 0;
    int          checks = 0;
    int          up_cnt;
    logic [14:0] up_or;

    // Operation-level model: edit index 0..3, field cursor, blink, idle ticks.
    int          m_st, m_cur, m_idle;
    logic        m_blink;
    int          c_base [4] = '{0, 0, 3, 9};

    edit_sequencer #(.TIMEOUT_TICKS(40), .REPEAT_DELAY(4)) dut (
        .clock_50MHz (clk),
        .reset       (rst_n),
        .tick_4Hz    (tick),
        .key_mode_n  (kmode),
        .key_shift_n (kshift),
        .key_up_n    (kup),
        .set         (set),
        .up          (up),
        .select      (select),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (up !== 15'd0) begin
                up_cnt++;
                up_or = up_or | up;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; kmode = 1'b1; kshift = 1'b1; kup = 1'b1; tick = 1'b0;
        cycles(4);
        rst_n = 1'b1;
        cycles(3);
        m_st = 0; m_cur = 0; m_idle = 0; m_blink = 1'b0;
    endtask

    task automatic press(input int k);
        up_cnt = 0; up_or = 15'd0;
        if (k == 0) kmode = 1'b0;
        else if (k == 1) kshift = 1'b0;
        else kup = 1'b0;
        cycles(6);
        kmode = 1'b1; kshift = 1'b1; kup = 1'b1;
        cycles(6);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycles(4);
        tick = 1'b0;
        cycles(4);
    endtask

    function automatic logic [2:0] exp_set();
        return (m_st == 0) ? 3'b000 : 3'(1 << (m_st - 1));
    endfunction

    function automatic logic [14:0] exp_sel();
        return (m_st == 0) ? 15'd0 : 15'(1 << (c_base[m_st] + m_cur));
    endfunction

    task automatic model_press(input int k);
        if (k == 0) begin
            m_st = (m_st + 1) % 4; m_cur = 0; m_idle = 0; m_blink = (m_st != 0);
        end else if (m_st != 0) begin
            m_idle = 0;
            if (k == 1) m_cur = (m_cur + 1) % ((m_st == 1) ? 3 : 6);
        end
    endtask

    task automatic model_tick();
        if (m_st != 0) begin
            m_blink = ~m_blink;
            m_idle++;
            if (m_idle >= 40) begin
                m_st = 0; m_cur = 0; m_idle = 0; m_blink = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        kmode = 1'b0; kup = 1'b0; rst_n = 1'b0;
        cycles(3);
        do_reset();
        checks++; if (set !== 3'b000) begin errors++; $display("FAIL reset_set got=%b exp=000", set); end
        checks++; if (up !== 15'd0) begin errors++; $display("FAIL reset_up got=%h exp=0", up); end
        checks++; if (select !== 15'd0) begin errors++; $display("FAIL reset_select got=%h exp=0", select); end
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink got=%b exp=0", blink); end
    endtask

    task automatic test_mode();
        do_reset();
        press(0);
        checks++; if (set !== 3'b001) begin errors++; $display("FAIL mode1_set got=%b exp=001", set); end
        checks++; if (select !== 15'h0001) begin errors++; $display("FAIL mode1_select got=%h exp=0001", select); end
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL mode1_blink got=%b exp=1", blink); end
        press(0);
        checks++; if (set !== 3'b010) begin errors++; $display("FAIL mode2_set got=%b exp=010", set); end
        checks++; if (select !== 15'h0008) begin errors++; $display("FAIL mode2_select got=%h exp=0008", select); end
    endtask

    task automatic test_shift_date();
        logic [14:0] u [4];
        logic [14:0] e;
        for (int i = 1; i <= 6; i++) begin
            press(1);
            e = 15'(1 << (3 + (i % 6)));
            checks++;
            if (select !== e) begin errors++; $display("FAIL shift_select step=%0d got=%h exp=%h", i, select, e); end
        end
        press(1); press(1);
        kup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            u[i] = up;
        end
        checks++;
        if (u[0] !== 15'd0 || u[1] !== 15'd0 || u[2] !== 15'h0020 || u[3] !== 15'd0) begin
            errors++;
            $display("FAIL up_latency got=%h,%h,%h,%h exp=0000,0000,0020,0000", u[0], u[1], u[2], u[3]);
        end
        up_cnt = 0; up_or = 15'd0;
        cycles(4); kup = 1'b1; cycles(6);
        checks++; if (up_cnt !== 0) begin errors++; $display("FAIL up_single got=%0d exp=0 extra strobes", up_cnt); end
    endtask

    task automatic test_repeat();
        do_reset();
        press(0);
        up_cnt = 0; up_or = 15'd0;
        kup = 1'b0;
        cycles(6);
        for (int i = 0; i < 8; i++) do_tick();
        kup = 1'b1;
        cycles(6);
        checks++; if (up_cnt !== 5) begin errors++; $display("FAIL repeat_count got=%0d exp=5", up_cnt); end
        checks++; if (up_or !== 15'h0001) begin errors++; $display("FAIL repeat_bits got=%h exp=0001", up_or); end
        up_cnt = 0; up_or = 15'd0;
        for (int i = 0; i < 3; i++) do_tick();
        checks++; if (up_cnt !== 0) begin errors++; $display("FAIL repeat_release got=%0d exp=0", up_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        press(0); press(0); press(0);
        for (int i = 0; i < 39; i++) do_tick();
        checks++; if (set !== 3'b100) begin errors++; $display("FAIL timeout_early_set got=%b exp=100", set); end
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL timeout_blink39 got=%b exp=0", blink); end
        do_tick();
        checks++;
        if (set !== 3'b000 || select !== 15'd0 || blink !== 1'b0) begin
            errors++;
            $display("FAIL timeout_exit got set=%b sel=%h blink=%b exp 000/0000/0", set, select, blink);
        end
    endtask

    task automatic test_priority();
        do_reset();
        press(0);
        up_cnt = 0; up_or = 15'd0;
        kmode = 1'b0; kup = 1'b0;
        cycles(6);
        kmode = 1'b1; kup = 1'b1;
        cycles(6);
        checks++; if (set !== 3'b010) begin errors++; $display("FAIL prio_mode_set got=%b exp=010", set); end
        checks++; if (up_cnt !== 0) begin errors++; $display("FAIL prio_mode_up got=%0d exp=0", up_cnt); end
        up_cnt = 0; up_or = 15'd0;
        kshift = 1'b0; kup = 1'b0;
        cycles(6);
        kshift = 1'b1; kup = 1'b1;
        cycles(6);
        checks++;
        if (select !== 15'h0010 || up_cnt !== 0) begin
            errors++;
            $display("FAIL prio_shift got sel=%h strobes=%0d exp 0010/0", select, up_cnt);
        end
        up_cnt = 0; up_or = 15'd0;
        kup = 1'b0;
        cycles(1);
        rst_n = 1'b0;
        cycles(5);
        kup = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
        checks++;
        if (up_cnt !== 0 || set !== 3'b000) begin
            errors++;
            $display("FAIL reset_inflight got strobes=%0d set=%b exp 0/000", up_cnt, set);
        end
    endtask

    task automatic test_random();
        int          op, exp_cnt;
        logic [14:0] exp_up;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 4));
            exp_up = 15'd0; exp_cnt = 0;
            if (op <= 2) begin
                if (op == 2 && m_st != 0) begin
                    exp_up = 15'(1 << (c_base[m_st] + m_cur));
                    exp_cnt = 1;
                end
                press(op);
                model_press(op);
            end else begin
                up_cnt = 0; up_or = 15'd0;
                do_tick();
                model_tick();
            end
            checks++;
            if (set !== exp_set() || select !== exp_sel() || blink !== m_blink) begin
                errors++;
                $display("FAIL rand_state n=%0d op=%0d got set=%b sel=%h blink=%b exp %b/%h/%b",
                         n, op, set, select, blink, exp_set(), exp_sel(), m_blink);
            end
            checks++;
            if (up_cnt !== exp_cnt || up_or !== exp_up) begin
                errors++;
                $display("FAIL rand_up n=%0d op=%0d got cnt=%0d bits=%h exp %0d/%h",
                         n, op, up_cnt, up_or, exp_cnt, exp_up);
            end
        end
    endtask

    initial begin
        up_cnt = 0; up_or = 15'd0;
        rst_n = 1'b0; kmode = 1'b1; kshift = 1'b1; kup = 1'b1; tick = 1'b0;
        test_reset();
        test_mode();
        test_shift_date();
        test_repeat();
        test_timeout();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
